// File: rtl/conv3x3_stream_lb.sv
// Streaming 3x3 convolution over a raster pixel stream using two line buffers.
// Runtime-loadable kernel, arithmetic post-shift, abs/ReLU output modes, border pixels forced to 0.
module conv3x3_stream_lb #(
  parameter int unsigned IMG_W = 256,
  parameter int unsigned IMG_H = 256,
  parameter int unsigned BITW  = 8,
  parameter int unsigned KW    = 8,
  parameter int unsigned ACCW  = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            k_we,
  input  logic [3:0]      k_addr,
  input  logic [KW-1:0]   k_data,
  input  logic [3:0]      shift,
  input  logic            mode,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [BITW-1:0] s_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [BITW-1:0] m_data,
  output logic            m_sof,
  output logic            m_eol
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic signed [KW-1:0] SOBEL_X [9] = '{
    KW'(-1), KW'(0), KW'(1),
    KW'(-2), KW'(0), KW'(2),
    KW'(-1), KW'(0), KW'(1)
  };

  logic [1:0]             state, state_nxt;
  logic [CW-1:0]          in_c, out_c;
  logic [RW-1:0]          in_r, out_r;
  logic [BITW-1:0]        lb1 [IMG_W];
  logic [BITW-1:0]        lb2 [IMG_W];
  logic [BITW-1:0]        wa [3];
  logic [BITW-1:0]        wb [3];
  logic [BITW-1:0]        nc [3];
  logic signed [KW-1:0]   k_stg [9];
  logic signed [KW-1:0]   k_act [9];
  logic [3:0]             shift_act;
  logic                   mode_act;
  logic                   rdy_en;
  logic                   in_fire, in_last, out_load, flush_all, border;
  logic signed [ACCW-1:0] acc, sh, mag;
  logic [BITW-1:0]        pix;

  assign s_ready = rdy_en && (state != S_FLUSH) && (!m_valid || m_ready || state == S_FILL);

  // Next state and output-load control.
  always_comb begin
    state_nxt = state;
    out_load  = 1'b0;
    in_fire   = s_valid && s_ready;
    in_last   = (in_r == RW'(IMG_H - 1)) && (in_c == CW'(IMG_W - 1));
    flush_all = (out_r == '0) && (out_c == '0);
    case (state)
      S_FILL: begin
        if (in_fire && in_r == RW'(1) && in_c == '0) state_nxt = S_RUN;
      end
      S_RUN: begin
        out_load = in_fire;
        if (in_fire && in_last) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        out_load = !flush_all && (!m_valid || m_ready);
        if (flush_all && m_valid && m_ready) state_nxt = S_FILL;
      end
      default: state_nxt = S_FILL;
    endcase
  end

  // Window: column ci-2 (wa), ci-1 (wb), live column (nc); row 0 is the oldest line.
  always_comb begin
    nc[0] = lb2[in_c];
    nc[1] = lb1[in_c];
    nc[2] = s_data;
    acc   = '0;
    for (int i = 0; i < 3; i++) begin
      acc = acc + ACCW'(k_act[3*i])   * ACCW'($signed({1'b0, wa[i]}))
                + ACCW'(k_act[3*i+1]) * ACCW'($signed({1'b0, wb[i]}))
                + ACCW'(k_act[3*i+2]) * ACCW'($signed({1'b0, nc[i]}));
    end
    sh     = acc >>> shift_act;
    mag    = sh[ACCW-1] ? -sh : sh;
    border = (out_r == '0) || (out_r == RW'(IMG_H - 1)) || (out_c == '0) || (out_c == CW'(IMG_W - 1));
    if (border || (mode_act && sh[ACCW-1])) pix = '0;
    else if (mag[ACCW-1] || (|mag[ACCW-2:BITW])) pix = '1;
    else pix = mag[BITW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FILL;
    else     state <= state_nxt;
  end

  // Counters, kernel registers and the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en    <= 1'b0;
      in_c      <= '0;
      in_r      <= '0;
      out_c     <= '0;
      out_r     <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_sof     <= 1'b0;
      m_eol     <= 1'b0;
      shift_act <= '0;
      mode_act  <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        k_stg[i] <= SOBEL_X[i];
        k_act[i] <= SOBEL_X[i];
      end
    end else begin
      rdy_en <= 1'b1;
      if (k_we && k_addr < 4'd9) k_stg[k_addr] <= $signed(k_data);
      if (in_fire) begin
        if (in_r == '0 && in_c == '0) begin
          k_act     <= k_stg;
          shift_act <= shift;
          mode_act  <= mode;
        end
        if (in_c == CW'(IMG_W - 1)) begin
          in_c <= '0;
          in_r <= (in_r == RW'(IMG_H - 1)) ? '0 : in_r + RW'(1);
        end else begin
          in_c <= in_c + CW'(1);
        end
      end
      if (out_load) begin
        m_valid <= 1'b1;
        m_data  <= pix;
        m_sof   <= (out_r == '0) && (out_c == '0);
        m_eol   <= (out_c == CW'(IMG_W - 1));
        if (out_c == CW'(IMG_W - 1)) begin
          out_c <= '0;
          out_r <= (out_r == RW'(IMG_H - 1)) ? '0 : out_r + RW'(1);
        end else begin
          out_c <= out_c + CW'(1);
        end
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
        m_sof   <= 1'b0;
        m_eol   <= 1'b0;
      end
    end
  end

  // Line buffers and window shift; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      lb2[in_c] <= lb1[in_c];
      lb1[in_c] <= s_data;
      for (int i = 0; i < 3; i++) begin
        wa[i] <= wb[i];
        wb[i] <= nc[i];
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_stream_lb.sv
// Bench for conv3x3_stream_lb: directed step-image table, kernel reload, random backpressure
// frames against a plain-arithmetic convolution model, and asynchronous mid-frame reset.
module tb_conv3x3_stream_lb;
  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  typedef struct { logic [7:0] d; logic sof; logic eol; } out_t;
  typedef struct { int lo; int hi; int sh; bit md; int edge_v; } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       k_we = 1'b0;
  logic [3:0] k_addr = '0;
  logic [7:0] k_data = '0;
  logic [3:0] shift = '0;
  logic       mode = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_sof;
  logic       m_eol;

  always #5 clk = ~clk;

  conv3x3_stream_lb #(.IMG_W(W), .IMG_H(H), .BITW(8), .KW(8), .ACCW(20)) dut (
    .clk(clk), .rst(rst), .k_we(k_we), .k_addr(k_addr), .k_data(k_data),
    .shift(shift), .mode(mode), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] in_q [$];
  out_t out_q [$];
  out_t exp_q [$];
  bit   acc_now;
  int   acc_frame, t10, tv, cyc;
  bit   seen_v, prev_stall;
  out_t prev_o, smp;
  int   mid_at = 0;
  int   mid_shift = 0;
  int   new_k [9];
  int   sobel [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  int   img [N];

  // Negedge sampler: records transfers and checks output stability under stall.
  always @(negedge clk) begin
    cyc++;
    acc_now = s_valid && s_ready;
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        n_checks++;
        if (!m_valid || m_data !== prev_o.d || m_sof !== prev_o.sof || m_eol !== prev_o.eol) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%0b d=%0d sof=%0b eol=%0b, want v=1 d=%0d sof=%0b eol=%0b",
                   m_valid, m_data, m_sof, m_eol, prev_o.d, prev_o.sof, prev_o.eol);
        end
      end
      if (acc_now) begin
        acc_frame++;
        if (acc_frame == 10) t10 = cyc;
      end
      if (m_valid && !seen_v) begin
        seen_v = 1'b1;
        tv = cyc;
      end
      smp.d = m_data; smp.sof = m_sof; smp.eol = m_eol;
      if (m_valid && m_ready) out_q.push_back(smp);
      prev_stall = m_valid && !m_ready;
      prev_o = smp;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic cmp_frames(input string tag);
    chk({tag, "_count"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_checks++;
      if (out_q[i].d !== exp_q[i].d || out_q[i].sof !== exp_q[i].sof || out_q[i].eol !== exp_q[i].eol) begin
        n_fail++;
        $display("FAIL %s out%0d: got d=%0d sof=%0b eol=%0b, want d=%0d sof=%0b eol=%0b", tag, i,
                 out_q[i].d, out_q[i].sof, out_q[i].eol, exp_q[i].d, exp_q[i].sof, exp_q[i].eol);
      end
    end
  endtask

  // Reference: direct 3x3 correlation on the frame array, border forced to 0.
  function automatic void model_frame(input int im[N], input int k[9], input int sh, input bit md);
    int r, c, s, v;
    out_t o;
    for (int i = 0; i < N; i++) begin
      r = i / W; c = i % W; s = 0; v = 0;
      if (r > 0 && r < H - 1 && c > 0 && c < W - 1) begin
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            s += k[(dr + 1) * 3 + dc + 1] * im[(r + dr) * W + c + dc];
        s = s >>> sh;
        if (md) v = (s < 0) ? 0 : s;
        else    v = (s < 0) ? -s : s;
        if (v > 255) v = 255;
      end
      o.d = 8'(v); o.sof = (i == 0); o.eol = (c == W - 1);
      exp_q.push_back(o);
    end
  endfunction

  function automatic void step_expect(input int edge_v);
    out_t o;
    for (int i = 0; i < N; i++) begin
      o.d   = ((i / W) >= 1 && (i / W) <= H - 2 && ((i % W) == 3 || (i % W) == 4)) ? 8'(edge_v) : 8'd0;
      o.sof = (i == 0);
      o.eol = ((i % W) == W - 1);
      exp_q.push_back(o);
    end
  endfunction

  task automatic fill_step(input int lo, input int hi);
    for (int i = 0; i < N; i++) img[i] = ((i % W) < 4) ? lo : hi;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) img[i] = int'($urandom_range(255, 0));
  endtask

  task automatic push_frame();
    for (int i = 0; i < N; i++) in_q.push_back(8'(img[i]));
  endtask

  task automatic write_k(input int addr, input int val);
    @(posedge clk); #1;
    k_we = 1'b1; k_addr = 4'(addr); k_data = 8'(val);
    @(posedge clk); #1;
    k_we = 1'b0;
  endtask

  // Drives queued pixels and backpressure until n_out outputs arrive (or reset point reached).
  task automatic stream(input int n_out, input bit rv, input bit rr, input int rst_at);
    int acc_total = 0;
    int kw = 0;
    int c = 0;
    while (out_q.size() < n_out && c < 5000) begin
      @(posedge clk); #1;
      c++;
      if (acc_now) begin
        void'(in_q.pop_front());
        acc_total++;
      end
      if (rst_at > 0 && acc_total >= rst_at) break;
      k_we = 1'b0;
      if (mid_at > 0 && acc_total >= mid_at && kw < 9) begin
        k_we = 1'b1; k_addr = 4'(kw); k_data = 8'(new_k[kw]);
        if (kw == 0) shift = 4'(mid_shift);
        kw++;
      end
      s_valid = (in_q.size() > 0) && (!rv || $urandom_range(1, 0) == 1);
      s_data  = (in_q.size() > 0) ? in_q[0] : 8'd0;
      m_ready = !rr || ($urandom_range(1, 0) == 1);
    end
    k_we = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    if (c >= 5000) begin
      n_checks++; n_fail++;
      $display("FAIL stream_timeout: got %0d outputs, want %0d", out_q.size(), n_out);
    end
  endtask

  initial begin
    vec_t tbl [6];
    int   rk [9];
    int   rsh;
    bit   rmd;
    tbl[0] = '{77, 77, 0, 1'b0, 0};
    tbl[1] = '{0, 255, 0, 1'b0, 255};
    tbl[2] = '{255, 0, 0, 1'b0, 255};
    tbl[3] = '{255, 0, 0, 1'b1, 0};
    tbl[4] = '{0, 255, 0, 1'b1, 255};
    tbl[5] = '{0, 100, 2, 1'b0, 100};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data",  int'(m_data), 0);
    chk("rst_m_sof",   int'(m_sof), 0);
    chk("rst_m_eol",   int'(m_eol), 0);
    chk("rst_s_ready", int'(s_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;

    for (int t = 0; t < 6; t++) begin
      shift = 4'(tbl[t].sh); mode = tbl[t].md;
      fill_step(tbl[t].lo, tbl[t].hi);
      push_frame();
      out_q.delete(); exp_q.delete();
      step_expect(tbl[t].edge_v);
      seen_v = 1'b0; acc_frame = 0;
      stream(N, 1'b0, 1'b0, 0);
      cmp_frames($sformatf("vec%0d", t));
      if (t == 0) chk("first_valid_latency", tv - t10, 1);
    end

    // Kernel/shift change mid-frame only applies to the following frame.
    shift = 4'd2; mode = 1'b0;
    for (int i = 0; i < 9; i++) new_k[i] = (i == 4) ? 1 : 0;
    mid_at = 20; mid_shift = 0;
    fill_step(0, 100); push_frame();
    out_q.delete(); exp_q.delete();
    step_expect(100);
    stream(N, 1'b0, 1'b0, 0);
    cmp_frames("midwrite_cur");
    mid_at = 0;
    fill_rand(); push_frame();
    out_q.delete(); exp_q.delete();
    model_frame(img, new_k, 0, 1'b0);
    stream(N, 1'b0, 1'b0, 0);
    cmp_frames("identity_next");

    // Random kernel, three back-to-back frames under random valid/ready.
    for (int i = 0; i < 9; i++) begin
      rk[i] = int'($urandom_range(255, 0)) - 128;
      write_k(i, rk[i]);
    end
    write_k(12, 8'h55);
    rsh = int'($urandom_range(3, 0)); rmd = 1'($urandom_range(1, 0));
    shift = 4'(rsh); mode = rmd;
    out_q.delete(); exp_q.delete();
    for (int f = 0; f < 3; f++) begin
      fill_rand(); push_frame();
      model_frame(img, rk, rsh, rmd);
    end
    stream(3 * N, 1'b1, 1'b1, 0);
    cmp_frames("rand3");

    // Asynchronous reset mid-frame, then a clean frame with the default kernel.
    shift = 4'd0; mode = 1'b0;
    fill_rand(); push_frame();
    out_q.delete(); exp_q.delete();
    stream(N, 1'b0, 1'b0, 20);
    #3 rst = 1'b1;
    #1;
    chk("mrst_m_valid", int'(m_valid), 0);
    chk("mrst_m_data",  int'(m_data), 0);
    chk("mrst_m_sof",   int'(m_sof), 0);
    chk("mrst_m_eol",   int'(m_eol), 0);
    chk("mrst_s_ready", int'(s_ready), 0);
    in_q.delete(); s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    out_q.delete(); exp_q.delete();
    fill_rand(); push_frame();
    model_frame(img, sobel, 0, 1'b0);
    stream(N, 1'b0, 1'b1, 0);
    cmp_frames("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/conv3x3_stream_lb.md
Name: conv3x3_stream_lb

Overview:
- Synthesizable streaming 3x3 2D convolution with two internal line buffers, replacing the frame-memory behavioural convolution model.
- Accepts a raster-order pixel stream (valid/ready) and emits a same-size raster output stream.
- Border pixels (first/last row and column) output 0.
- Kernel is runtime-loadable, with selectable post-scale shift and output mode. Sits between pixel source (image loader/DMA) and PGM writer/downstream filters.

Parameters:
- IMG_W, 256, pixels per row (≥4).
- IMG_H, 256, rows per frame (≥3).
- BITW, 8, pixel width, unsigned.
- KW, 8, kernel coefficient width, signed.
- ACCW, 20, accumulator width, signed; must hold 9·(2^BITW−1)·2^(KW−1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- k_we  in  1  kernel coefficient write strobe.
- k_addr  in  4  coefficient index 0..8, row-major (k00,k01,k02,k10..k22); 9..15 ignored.
- k_data  in  KW  signed coefficient.
- shift  in  4  arithmetic right shift applied to the sum.
- mode  in  1  0 = absolute value then clamp; 1 = clamp negatives to 0 (ReLU).
- s_valid  in  1  input pixel valid.
- s_ready  out  1  block accepts input pixel.
- s_data  in  BITW  input pixel.
- m_valid  out  1  output pixel valid.
- m_ready  in  1  downstream accepts output.
- m_data  out  BITW  output pixel.
- m_sof  out  1  marks output pixel (0,0).
- m_eol  out  1  marks last pixel of each output row.

Behaviour:
- Reset values (async): m_valid=0, m_data=0, m_sof=0, m_eol=0, s_ready=0 during reset. Counters=0, state=FILL. Staging and active kernels both = SobelX (−1 0 1; −2 0 2; −1 0 1). Line buffer contents need no reset.
- Kernel: k_we writes the staging register at k_addr in any state. Staging is copied to the active kernel on acceptance of input pixel (0,0) only. Mid-frame writes take effect next frame. shift and mode are sampled with the same rule.
- Handshake: a transfer occurs when valid&&ready on the same edge. m_valid/m_data/m_sof/m_eol are held stable while m_valid && !m_ready. s_ready = (state≠FLUSH) && (!m_valid || m_ready || state==FILL). No pixel is dropped or duplicated under any backpressure pattern.
- States:
  - FILL: accept the first IMG_W+1 pixels of a frame; no output. After the (IMG_W+1)th accept → RUN.
  - RUN: each accepted input n produces output index n−(IMG_W+1), registered on the same edge (1-cycle latency from accept to m_valid). After the last frame pixel (IMG_W·IMG_H−1) is accepted → FLUSH.
  - FLUSH: s_ready=0. Emits the remaining IMG_W+1 outputs (last row plus final pixel of the previous row) with one output per cycle when not stalled. After the last output transfers → FILL for the next frame.
- Window: 3x3 register window fed by two line buffers of IMG_W entries (row r−1, r−2) plus the live pixel. Column/row counters wrap at IMG_W/IMG_H.
- Arithmetic for output (r,c) with 0<r<IMG_H−1 and 0<c<IMG_W−1:
  - sum = Σ k_ij·$signed({1'b0,p}), in ACCW bits.
  - s = sum >>> shift.
  - mode 0: v = |s|, clamped to 2^BITW−1; the most negative value clamps to max.
  - mode 1: v = 0 if s<0, else min(s, 2^BITW−1).
- Border outputs (r∈{0,IMG_H−1} or c∈{0,IMG_W−1}) are 0 regardless of kernel. The window never wraps across rows.
- Flags: m_sof=1 only with output (0,0); m_eol=1 with every output where c=IMG_W−1.
- Simultaneous accept of input and output on the same edge in RUN sustains 1 pixel/cycle.
- Back-to-back frames: frame 2's first pixel is accepted only after FLUSH completes.
- Reset mid-frame: partial frame is discarded; the next pixel accepted after reset is treated as (0,0).

Test Plan (IMG_W=8, IMG_H=6, BITW=8, default kernel unless noted):
1. Constant image, all 77, m_ready=1 → 48 outputs, all 0; m_sof on output 0; m_eol on outputs 7,15,…,47; first m_valid 1 cycle after the 10th accept.
2. Vertical step (cols 0–3 = 0, cols 4–7 = 255), mode 0, shift 0 → rows 1–4 cols 3,4 = 255 (sum 1020 clamped); all other outputs 0.
3. Inverted step (cols 0–3 = 255, cols 4–7 = 0): mode 0 → cols 3,4 = 255; mode 1 → all 0.
4. Step of 0/100 with shift=2 → cols 3,4 = 100 (400>>>2). Then write k11=1, all others 0, mid-frame → current frame unchanged; next frame interior = input, border = 0.
5. Random s_valid and m_ready (≈50%) over 3 back-to-back random frames → output sequence bit-exact vs golden model; no loss or duplication; m_data held stable during stall.
6. Assert rst asynchronously mid-frame (between edges) → outputs 0 immediately; next full frame is correct and kernel reverts to SobelX.
